// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit multiplexed BCD display scan controller
//
// Purpose: time-multiplexes four BCD digits onto a common segment bus.
// Each digit slot is a dark guard interval followed by the digit's anode
// being driven. A frame's digit values and decimal points are captured at
// frame start, so input changes mid-frame never show until the next frame.
// Optional leading-zero blanking darkens the upper zero digits.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   en         - scan enable; low returns to IDLE with the display dark
//   digits     - four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      - decimal-point request per digit, active-high
//   blank_lz   - leading-zero blanking enable
//   bcd        - BCD code of the addressed digit (to external decoder)
//   an         - anode enables, active-low, bit i = digit i
//   dp         - decimal-point segment, active-low
//   digit_sel  - index of the addressed digit
//   frame_tick - one-cycle pulse when a full four-digit frame completes

module display_scan_ctrl #(
  parameter int ON_CYC    = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_tick
);

  localparam int MAX_CYC = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   snap, snap_nxt;
  logic [3:0]    dp_snap, dp_snap_nxt;
  logic [1:0]    sel_nxt;
  logic [3:0]    bcd_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;
  logic          tick_nxt;
  logic          guard_done, show_done;
  logic          lz3, lz2, lz1, blanked;

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0:    nibble = v[3:0];
      2'd1:    nibble = v[7:4];
      2'd2:    nibble = v[11:8];
      default: nibble = v[15:12];
    endcase
  endfunction

  assign guard_done = (cnt == GUARD_LAST);
  assign show_done  = (cnt == ON_LAST);

  // State and output registers; every output is driven from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      snap       <= '0;
      dp_snap    <= '0;
      digit_sel  <= '0;
      bcd        <= '0;
      an         <= 4'hF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      snap       <= snap_nxt;
      dp_snap    <= dp_snap_nxt;
      digit_sel  <= sel_nxt;
      bcd        <= bcd_nxt;
      an         <= an_nxt;
      dp         <= dp_nxt;
      frame_tick <= tick_nxt;
    end
  end

  // Next-state logic; dropping en abandons the frame from any active state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = GUARD;
      GUARD:   if (!en) state_nxt = IDLE;
               else if (guard_done) state_nxt = SHOW;
      SHOW:    if (!en) state_nxt = IDLE;
               else if (show_done) state_nxt = GUARD;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the frame snapshot.
  always_comb begin
    snap_nxt    = snap;
    dp_snap_nxt = dp_snap;
    sel_nxt     = digit_sel;
    bcd_nxt     = bcd;
    tick_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          snap_nxt    = digits;
          dp_snap_nxt = dp_in;
          sel_nxt     = 2'd0;
          bcd_nxt     = digits[3:0];
        end
      end
      GUARD: begin
        if (!en) sel_nxt = 2'd0;
      end
      SHOW: begin
        if (!en) begin
          sel_nxt = 2'd0;
        end else if (show_done) begin
          if (digit_sel == 2'd3) begin
            // Frame wrap: re-capture so the next frame sees fresh inputs.
            sel_nxt     = 2'd0;
            snap_nxt    = digits;
            dp_snap_nxt = dp_in;
            bcd_nxt     = digits[3:0];
            tick_nxt    = 1'b1;
          end else begin
            sel_nxt = digit_sel + 2'd1;
            bcd_nxt = nibble(snap, digit_sel + 2'd1);
          end
        end
      end
      default: sel_nxt = 2'd0;
    endcase

    // The counter restarts on every state change and idles at zero.
    if ((state_nxt != state) || (state == IDLE)) cnt_nxt = '0;
    else                                         cnt_nxt = cnt + 1'b1;

    // A digit is a leading zero when it and every digit above it are zero.
    lz3 = (snap_nxt[15:12] == 4'd0);
    lz2 = lz3 && (snap_nxt[11:8] == 4'd0);
    lz1 = lz2 && (snap_nxt[7:4] == 4'd0);
    case (sel_nxt)
      2'd3:    blanked = blank_lz && lz3;
      2'd2:    blanked = blank_lz && lz2;
      2'd1:    blanked = blank_lz && lz1;
      default: blanked = 1'b0;
    endcase

    an_nxt = 4'hF;
    dp_nxt = 1'b1;
    if ((state_nxt == SHOW) && !blanked) begin
      an_nxt = ~(4'b0001 << sel_nxt);
      dp_nxt = ~dp_snap_nxt[sel_nxt];
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
//
// Purpose: drives directed scenarios and random traffic into
// display_scan_ctrl (ON_CYC=4, GUARD_CYC=2) and compares every output each
// cycle against a frame-position reference model.
// Ports: none (top-level bench).

module tb_display_scan_ctrl;

  localparam int ON    = 4;
  localparam int GD    = 2;
  localparam int SLOT  = ON + GD;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  display_scan_ctrl #(.ON_CYC(ON), .GUARD_CYC(GD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an         (an),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: position within the frame plus the captured frame data.
  bit          m_active;
  int          m_t;
  logic [15:0] m_snap;
  logic [3:0]  m_dps;
  logic [3:0]  m_bcd;
  logic        m_tick;
  logic [3:0]  e_an;
  logic        e_dp;
  logic [1:0]  e_sel;

  int first_lit, tick1, tick2, guard_n;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_blank(input logic [15:0] s, input int k, input logic bl);
    return bl && (k > 0) && ((s >> (4 * k)) == 16'd0);
  endfunction

  task automatic derive();
    int slot, ph;
    slot  = m_t / SLOT;
    ph    = m_t % SLOT;
    e_sel = 2'(slot);
    m_bcd = m_snap[4*slot +: 4];
    if ((ph < GD) || is_blank(m_snap, slot, blank_lz)) begin
      e_an = 4'hF;
      e_dp = 1'b1;
    end else begin
      e_an = ~(4'b0001 << slot);
      e_dp = ~m_dps[slot];
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_active = 0; m_t = 0; m_snap = '0; m_dps = '0; m_bcd = '0;
      m_tick = 1'b0; e_an = 4'hF; e_dp = 1'b1; e_sel = 2'd0;
    end else if (!m_active) begin
      m_tick = 1'b0;
      if (en) begin
        m_active = 1; m_t = 0; m_snap = digits; m_dps = dp_in;
        derive();
      end
    end else if (!en) begin
      m_active = 0; m_tick = 1'b0; e_an = 4'hF; e_dp = 1'b1; e_sel = 2'd0;
    end else begin
      m_t++;
      m_tick = 1'b0;
      if (m_t == FRAME) begin
        m_t = 0; m_snap = digits; m_dps = dp_in; m_tick = 1'b1;
      end
      derive();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("an",         16'(an),         16'(e_an));
    chk("dp",         16'(dp),         16'(e_dp));
    chk("bcd",        16'(bcd),        16'(m_bcd));
    chk("digit_sel",  16'(digit_sel),  16'(e_sel));
    chk("frame_tick", 16'(frame_tick), 16'(m_tick));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; digits = '0; dp_in = '0; blank_lz = 1'b0;
    run(2);
    rst = 1'b0;
    run(3);

    // Basic scan of 1234, first anode latency and frame_tick spacing.
    digits = 16'h1234; en = 1'b1;
    first_lit = -1; tick1 = -1; tick2 = -1;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      step();
      if ((first_lit < 0) && (an !== 4'hF)) first_lit = i;
      if (frame_tick === 1'b1) begin
        if (tick1 < 0) tick1 = i;
        else if (tick2 < 0) tick2 = i;
      end
    end
    chk("first_anode_latency", 16'(first_lit), 16'(GD + 1));
    chk("frame_tick_gap", 16'(tick2 - tick1), 16'(FRAME));

    // Leading-zero blanking: 0045, then all zeros.
    rst = 1'b1; run(1); rst = 1'b0;
    digits = 16'h0045; blank_lz = 1'b1;
    run(FRAME + 2);
    digits = 16'h0000;
    run(2 * FRAME);

    // Mid-frame digit change is deferred to the next frame; dp on digit 2.
    rst = 1'b1; run(1); rst = 1'b0;
    blank_lz = 1'b0; dp_in = 4'b0100; digits = 16'h1234;
    run(SLOT + GD + 2);
    digits = 16'h9876;
    run(2 * FRAME);

    // en dropped during digit-2 SHOW, then re-raised.
    guard_n = 0;
    while (!(m_active && (m_t / SLOT == 2) && (m_t % SLOT >= GD)) && guard_n < 4 * FRAME) begin
      step();
      guard_n++;
    end
    chk("reach_digit2_show", 16'(guard_n < 4 * FRAME), 16'd1);
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(FRAME + 2);

    // Reset asserted on the frame_tick cycle.
    guard_n = 0;
    while (!m_tick && guard_n < 2 * FRAME) begin
      step();
      guard_n++;
    end
    chk("reach_frame_tick", 16'(m_tick), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(3);

    // Hex nibbles pass through unchanged, no blanking.
    rst = 1'b1; run(1); rst = 1'b0;
    digits = 16'hFA00; dp_in = 4'b0000; blank_lz = 1'b0;
    run(FRAME + 4);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0)  digits = rand_digits();
      if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
      en  = ($urandom_range(0, 59) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
